// File: rtl/cmul_pkg.sv
// Elaboration-time helpers for the pipelined constant multiplier:
// CSD recoding, result width, latency and adder-tree term layout.
package cmul_pkg;

  localparam int CSD_MAX_K = 17;

  function automatic int cmul_abs(input int c);
    return (c < 0) ? -c : c;
  endfunction

  function automatic int cmul_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 20; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Non-adjacent form: odd remainders pick +1 or -1 so the
  // next digit is always zero.
  function automatic int csd_digit(input int c, input int k);
    int n;
    int di;
    int d;
    n = cmul_abs(c);
    d = 0;
    for (int i = 0; i <= CSD_MAX_K; i++) begin
      di = 0;
      if ((n % 2) != 0) begin
        di = 2 - (n % 4);
        n = n - di;
      end
      if (i == k) d = di;
      n = n / 2;
    end
    return (c < 0) ? -d : d;
  endfunction

  function automatic int csd_count(input int c);
    int n;
    n = 0;
    for (int k = 0; k <= CSD_MAX_K; k++)
      if (csd_digit(c, k) != 0) n++;
    return n;
  endfunction

  // Slot of digit k among the nonzero digits below it.
  function automatic int csd_rank(input int c, input int k);
    int n;
    n = 0;
    for (int j = 0; j < k; j++)
      if (csd_digit(c, j) != 0) n++;
    return n;
  endfunction

  function automatic int cmul_c_bits(input int c);
    return cmul_clog2(cmul_abs(c) + 1);
  endfunction

  function automatic int cmul_o_width(input int iw, input int c);
    return iw + cmul_c_bits(c) + 1;
  endfunction

  function automatic int cmul_latency(input int c);
    int n;
    n = csd_count(c);
    if (n < 1) n = 1;
    return 1 + cmul_clog2(n);
  endfunction

  function automatic int cmul_terms_at(input int n, input int s);
    int t;
    t = (n < 1) ? 1 : n;
    for (int i = 0; i < s; i++) t = (t + 1) / 2;
    return t;
  endfunction

  function automatic int cmul_term_base(input int n, input int s);
    int b;
    b = 0;
    for (int j = 0; j < s; j++) b += cmul_terms_at(n, j);
    return b;
  endfunction

endpackage

// File: rtl/cmul_tree_stage.sv
// One registered pairwise-add level of the product tree.
// Ports: term bundle in/out with valid/ready; odd leftover passes through.
module cmul_tree_stage
  import cmul_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int W    = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_IN*W-1:0]             in_terms_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic [((N_IN+1)/2)*W-1:0]     out_terms_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i
);

  localparam int N_OUT = (N_IN + 1) / 2;

  logic [N_IN-1:0][W-1:0]  a;
  logic [N_OUT-1:0][W-1:0] sum;
  logic [N_OUT*W-1:0]      t_d, t_q;
  logic                    v_d, v_q;

  assign a = in_terms_i;

  always_comb begin
    sum = '0;
    for (int j = 0; j < N_IN / 2; j++)
      sum[j] = a[2*j] + a[2*j+1];
    if ((N_IN % 2) == 1)
      sum[N_OUT-1] = a[N_IN-1];
  end

  // An empty stage loads even while downstream is stalled.
  assign in_ready_o = !v_q || out_ready_i;

  always_comb begin
    v_d = v_q;
    t_d = t_q;
    if (in_ready_o) begin
      v_d = in_valid_i;
      if (in_valid_i) t_d = sum;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q <= 1'b0;
      t_q <= '0;
    end else begin
      v_q <= v_d;
      t_q <= t_d;
    end
  end

  assign out_terms_o = t_q;
  assign out_valid_o = v_q;

endmodule

// File: rtl/cmul_pipe.sv
// Pipelined constant multiplier: CSD partial products, then a tree.
// Ports: in_data/valid/ready sample side, out_data/valid/ready product.
module cmul_pipe
  import cmul_pkg::*;
#(
  parameter int I_WIDTH  = 8,
  parameter int I_SIGNED = 0,
  parameter int C_VAL    = 63
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [I_WIDTH-1:0]                       in_data_i,
  input  logic                                     in_valid_i,
  output logic                                     in_ready_o,
  output logic [cmul_o_width(I_WIDTH, C_VAL)-1:0]  out_data_o,
  output logic                                     out_valid_o,
  input  logic                                     out_ready_i
);

  localparam int C_BITS  = cmul_c_bits(C_VAL);
  localparam int O_WIDTH = cmul_o_width(I_WIDTH, C_VAL);
  localparam int N_TERMS = csd_count(C_VAL);
  localparam int LAT     = cmul_latency(C_VAL);
  localparam int N0      = cmul_terms_at(N_TERMS, 0);
  localparam int TOT     = cmul_term_base(N_TERMS, LAT);
  localparam int B_LAST  = cmul_term_base(N_TERMS, LAT - 1);

  logic [O_WIDTH-1:0]         x_ext;
  logic [N0-1:0][O_WIDTH-1:0] pp;
  logic [N0*O_WIDTH-1:0]      pp_d, pp_q;
  logic                       v0_d, v0_q;
  logic [TOT*O_WIDTH-1:0]     terms;
  logic [LAT-1:0]             valid;
  logic [LAT:0]               rdy;

  if (I_SIGNED != 0) begin : g_sx
    assign x_ext = {{(C_BITS+1){in_data_i[I_WIDTH-1]}}, in_data_i};
  end else begin : g_zx
    assign x_ext = {{(C_BITS+1){1'b0}}, in_data_i};
  end

  if (N_TERMS == 0) begin : g_zero
    assign pp = '0;
  end else begin : g_pp
    for (genvar k = 0; k <= C_BITS; k++) begin : g_k
      localparam int D  = csd_digit(C_VAL, k);
      localparam int IX = csd_rank(C_VAL, k);
      if (D > 0) begin : g_pos
        assign pp[IX] = x_ext << k;
      end else if (D < 0) begin : g_neg
        assign pp[IX] = -(x_ext << k);
      end
    end
  end

  assign rdy[LAT] = out_ready_i;
  assign rdy[0]   = !v0_q || rdy[1];

  always_comb begin
    v0_d = v0_q;
    pp_d = pp_q;
    if (rdy[0]) begin
      v0_d = in_valid_i;
      if (in_valid_i) pp_d = pp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v0_q <= 1'b0;
      pp_q <= '0;
    end else begin
      v0_q <= v0_d;
      pp_q <= pp_d;
    end
  end

  assign valid[0]                = v0_q;
  assign terms[N0*O_WIDTH-1:0]   = pp_q;

  // Every stage's terms live back to back in one flat vector.
  for (genvar s = 1; s < LAT; s++) begin : g_st
    localparam int NI = cmul_terms_at(N_TERMS, s - 1);
    localparam int NO = cmul_terms_at(N_TERMS, s);
    localparam int BI = cmul_term_base(N_TERMS, s - 1);
    localparam int BO = cmul_term_base(N_TERMS, s);
    cmul_tree_stage #(
      .N_IN (NI),
      .W    (O_WIDTH)
    ) u_stage (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_terms_i  (terms[BI*O_WIDTH +: NI*O_WIDTH]),
      .in_valid_i  (valid[s-1]),
      .in_ready_o  (rdy[s]),
      .out_terms_o (terms[BO*O_WIDTH +: NO*O_WIDTH]),
      .out_valid_o (valid[s]),
      .out_ready_i (rdy[s+1])
    );
  end

  assign out_data_o  = terms[B_LAST*O_WIDTH +: O_WIDTH];
  assign out_valid_o = valid[LAT-1];
  assign in_ready_o  = rdy[0];

endmodule

// File: doc/cmul_pipe.md
Name: cmul_pipe

Overview:
- Parametrised, pipelined constant-coefficient multiplier; the next generation of the team's 8-bit combinational shift-add constant multiplier.
- Generalised in four ways:
  - input width and input signedness are parameters;
  - the constant carries its own sign;
  - the constant is recoded into canonical signed digits (CSD) at elaboration;
  - partial products are summed in a registered pairwise adder tree with valid/ready flow control.
- Used in filter taps, scaling and FFT twiddle stages wherever a fixed coefficient feeds a streaming datapath.

Parameters:
- I_WIDTH, 8, input sample width (1..32).
- I_SIGNED, 0, 1 = input is two's complement; 0 = input is unsigned.
- C_VAL, 63, signed integer constant; |C_VAL| < 2^16; negative values allowed.
- Derived, not overridable:
  - C_BITS = clog2(|C_VAL|+1).
  - O_WIDTH = I_WIDTH + C_BITS + 1.
  - N_TERMS = number of nonzero CSD digits of C_VAL.
  - LAT = 1 + ceil(log2(max(N_TERMS,1))).

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- in_data_i  in  I_WIDTH  sample; interpreted per I_SIGNED.
- in_valid_i  in  1  sample present.
- in_ready_o  out  1  block accepts the sample this cycle.
- out_data_o  out  O_WIDTH  product in_data × C_VAL, two's complement.
- out_valid_o  out  1  product present.
- out_ready_i  in  1  downstream accepts the product.

Behaviour:
- Interface:
  - One clock domain: clk_i.
  - Reset is synchronous and active-high: rst_i, sampled on the rising edge of clk_i.
- Reset:
  - All stage valid bits clear to 0, so out_valid_o = 0.
  - All data registers clear to 0, so out_data_o = 0.
  - in_ready_o = 1 in the cycle after reset is released.
  - Reset mid-operation discards every in-flight sample; nothing from before reset is ever emitted after it.
- CSD recoding (elaboration time):
  - C_VAL = Σ d_k·2^k with d_k ∈ {-1,0,+1} and no two adjacent nonzero digits; k ranges 0..C_BITS.
  - A negative C_VAL negates every digit.
- Stage 0 (registered):
  - Input is sign- or zero-extended to O_WIDTH per I_SIGNED.
  - One partial product per nonzero digit: ±(x << k).
  - N_TERMS = 0 (C_VAL = 0) yields a single zero term.
- Stages 1..LAT-1 (registered):
  - Each stage adds its inputs pairwise.
  - An odd term count passes the leftover term through unchanged.
  - The final stage holds exactly one term, which drives out_data_o.
- Arithmetic:
  - All internal sums are O_WIDTH wide.
  - O_WIDTH is sized so that no overflow is possible for any input and any legal C_VAL; the result is exact.
- Latency: an accepted sample appears on out_data_o exactly LAT cycles later when out_ready_i is held high.
- Throughput: 1 sample per cycle with no back-pressure.
- Handshake:
  - Transfer on input when in_valid_i & in_ready_o; transfer on output when out_valid_o & out_ready_i.
  - Per-stage valid bit v[s]. Stage s loads when rdy[s] = !v[s] | rdy[s+1], with rdy[LAT] = out_ready_i.
  - in_ready_o = rdy[0], combinational from out_ready_i.
  - A stalled stage holds its data and valid bit unchanged.
  - Bubbles collapse: an empty stage loads even while downstream is stalled.
  - Output stability: while out_valid_o = 1 and out_ready_i = 0, out_data_o and out_valid_o hold stable.
- Capacity: at most LAT samples in flight. With the output stalled, in_ready_o drops once all stages are valid.
- Simultaneous input and output transfer in a full pipeline: the pipeline advances and the occupancy count is unchanged.
- Ordering: outputs leave in strict input order; no drops and no duplicates.

Decomposition:
- Package cmul_pkg holds elaboration-time functions:
  - csd_digit(c,k), returns -1/0/+1.
  - csd_count(c).
  - cmul_c_bits(c).
  - cmul_o_width(iw,c).
  - cmul_latency(c).
- One sub-module: cmul_tree_stage, parametrised by term count and width. It contains one registered pairwise-add level with its own valid bit and the rdy chain.
- The top level instantiates LAT-1 cmul_tree_stage instances after the partial-product register.

Test Plan:
- I_WIDTH=8, I_SIGNED=0, C_VAL=63 (CSD 64-1, LAT=2, O_WIDTH=15); out_ready_i=1; inputs 255, 1, 0 on consecutive cycles -> outputs 16065, 63, 0 on cycles 2, 3, 4 after first accept.
- I_SIGNED=1, C_VAL=-45 (CSD 64-16-4+1, LAT=3, O_WIDTH=15); inputs -128 and 127 -> outputs 5760 and -5715, each 3 cycles after accept.
- C_VAL=64 (LAT=1): input 3 -> output 192 one cycle later. C_VAL=0: input 200 -> output 0 one cycle later.
- Back-pressure, C_VAL=63: out_ready_i=0 while streaming 10, 20, 30, 40 -> in_ready_o goes low after 2 accepts; out_data_o holds 630 stably. Raise out_ready_i -> 630, 1260, 1890, 2520 emitted in order, none lost.
- Reset mid-stream: assert rst_i with 2 samples in flight -> next cycle out_valid_o=0 and out_data_o=0; no pre-reset sample ever appears afterwards.
- Random back-pressure, 10k random signed samples, I_WIDTH=12, C_VAL=-32767 -> scoreboard matches x×C exactly, in order.
